// File: rtl/or_gate_if.sv
// Operand/result bundle for the registered OR cell.
// The master drives operands and controls; the slave returns the registered result.
interface or_gate_if #(
   parameter int WIDTH = 1
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             in_valid;
   logic             acc;
   logic             clr;
   logic [WIDTH-1:0] F;
   logic             F_ANY;
   logic             out_valid;

   modport master (
      output A, B, in_valid, acc, clr,
      input  F, F_ANY, out_valid
   );

   modport slave (
      input  A, B, in_valid, acc, clr,
      output F, F_ANY, out_valid
   );
endinterface

// File: rtl/or_gate.sv
// Registered bitwise OR of two flag buses with sticky accumulate and synchronous clear.
// Defining OR_INPUT_REG_EN adds an input register stage (latency 2 instead of 1).
module or_gate #(
   parameter int WIDTH = 1
) (
   input logic      clk,
   input logic      rst,
   or_gate_if.slave bus
);
   logic [WIDTH-1:0] a_s;
   logic [WIDTH-1:0] b_s;
   logic             in_valid_s;
   logic             acc_s;
   logic             clr_s;
   logic [WIDTH-1:0] x_s;

   logic [WIDTH-1:0] f_q;
   logic [WIDTH-1:0] f_d;
   logic             f_any_q;
   logic             f_any_d;
   logic             out_valid_q;
   logic             out_valid_d;

`ifdef OR_INPUT_REG_EN
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] a_d;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] b_d;
   logic             in_valid_q;
   logic             in_valid_d;
   logic             acc_q;
   logic             acc_d;
   logic             clr_q;
   logic             clr_d;

   // Operands are zeroed when unqualified so undriven inputs never enter the stage.
   always_comb begin
      in_valid_d = bus.in_valid;
      acc_d      = bus.acc;
      clr_d      = bus.clr;
      a_d        = '0;
      b_d        = '0;
      if (bus.in_valid) begin
         a_d = bus.A;
         b_d = bus.B;
      end else begin
         a_d = '0;
         b_d = '0;
      end
   end

   // Input stage register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q        <= '0;
         b_q        <= '0;
         in_valid_q <= 1'b0;
         acc_q      <= 1'b0;
         clr_q      <= 1'b0;
      end else begin
         a_q        <= a_d;
         b_q        <= b_d;
         in_valid_q <= in_valid_d;
         acc_q      <= acc_d;
         clr_q      <= clr_d;
      end
   end

   assign a_s        = a_q;
   assign b_s        = b_q;
   assign in_valid_s = in_valid_q;
   assign acc_s      = acc_q;
   assign clr_s      = clr_q;
`else
   assign a_s        = bus.A;
   assign b_s        = bus.B;
   assign in_valid_s = bus.in_valid;
   assign acc_s      = bus.acc;
   assign clr_s      = bus.clr;
`endif

   assign x_s = a_s | b_s;

   // Result next-state: clear outranks accumulate, and F_ANY tracks the value being loaded.
   always_comb begin
      f_d         = f_q;
      out_valid_d = 1'b0;
      if (clr_s) begin
         if (in_valid_s) begin
            f_d         = x_s;
            out_valid_d = 1'b1;
         end else begin
            f_d         = '0;
            out_valid_d = 1'b0;
         end
      end else if (in_valid_s) begin
         if (acc_s) begin
            f_d = f_q | x_s;
         end else begin
            f_d = x_s;
         end
         out_valid_d = 1'b1;
      end else begin
         f_d         = f_q;
         out_valid_d = 1'b0;
      end
      f_any_d = |f_d;
   end

   // Result register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f_q         <= '0;
         f_any_q     <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         f_q         <= f_d;
         f_any_q     <= f_any_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.F         = f_q;
   assign bus.F_ANY     = f_any_q;
   assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_or_gate.sv
// Scoreboard bench for or_gate: the driver pushes expected results, a monitor pops and compares.
module tb_or_gate;
   localparam int W = 8;
`ifdef OR_INPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   typedef struct {
      int         due;
      logic [W-1:0] f;
      logic       any;
      logic       vld;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   errors;
   exp_t q[$];
   logic [W-1:0] model_f;

   or_gate_if #(.WIDTH(W)) bus ();
   or_gate #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Reference: spec rules applied to a whole word at once.
   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic v, input logic ac, input logic cl);
      exp_t e;
      @(negedge clk);
      bus.A = a; bus.B = b; bus.in_valid = v; bus.acc = ac; bus.clr = cl;
      if (v) model_f = (ac && !cl) ? (model_f | a | b) : (a | b);
      else if (cl) model_f = '0;
      e.due = cyc + LAT;
      e.f   = model_f;
      e.any = (model_f != '0);
      e.vld = v;
      q.push_back(e);
   endtask

   // Monitor: compare the entry due this cycle; otherwise nothing may be presented.
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         while (q.size() > 0 && q[0].due < cyc) begin
            void'(q.pop_front());
            checks++; errors++;
            $display("FAIL missed_entry at cycle %0d", cyc);
         end
         if (q.size() > 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("F", 64'(bus.F), 64'(e.f));
            chk("F_ANY", 64'(bus.F_ANY), 64'(e.any));
            chk("out_valid", 64'(bus.out_valid), 64'(e.vld));
         end else begin
            chk("idle_out_valid", 64'(bus.out_valid), 64'(1'b0));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      cyc = 0; checks = 0; errors = 0; model_f = '0;
      bus.A = '0; bus.B = '0; bus.in_valid = 1'b0; bus.acc = 1'b0; bus.clr = 1'b0;
      rst = 1'b1;
      #12;
      chk("reset_F", 64'(bus.F), 64'(0));
      chk("reset_F_ANY", 64'(bus.F_ANY), 64'(0));
      chk("reset_out_valid", 64'(bus.out_valid), 64'(0));
      @(negedge clk);
      rst = 1'b0;

      // Truth table on bit 0.
      drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
      drive(8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
      drive(8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
      drive(8'h01, 8'h01, 1'b1, 1'b0, 1'b0);
      drive(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);

      // Accumulate then clear priority.
      drive(8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
      drive(8'h00, 8'h10, 1'b1, 1'b1, 1'b0);
      drive(8'h80, 8'h00, 1'b1, 1'b1, 1'b0);
      drive(8'h02, 8'h00, 1'b1, 1'b1, 1'b1);
      drive(8'h5A, 8'hA5, 1'b0, 1'b0, 1'b1);

      // Hold with toggling operands.
      drive(8'h33, 8'h40, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++)
         drive(8'($urandom), 8'($urandom), 1'b0, 1'($urandom), 1'b0);

      // Asynchronous reset between edges while F is nonzero.
      drive(8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < LAT + 1; i++) drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_F", 64'(bus.F), 64'(0));
      chk("async_rst_F_ANY", 64'(bus.F_ANY), 64'(0));
      chk("async_rst_out_valid", 64'(bus.out_valid), 64'(0));
      q.delete();
      model_f = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) drive(8'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b0);
      drive(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++)
         drive(8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0),
               1'($urandom), 1'($urandom_range(0, 7) == 0));

      drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < LAT + 2; i++) @(negedge clk);
      chk("queue_drained", 64'(q.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
